// File: rtl/koala_feeder.sv
// Byte-stream to 64-bit block feeder for the Koala absorb/squeeze core, with digest capture.
// Optional 10* padding (0x01 marker plus extra pad block) is built when KOALA_FEEDER_PAD_EN is defined.
module koala_feeder (
  input  logic         clk,
  input  logic         arstn,
  input  logic         start,
  input  logic         empty,
  input  logic [256:0] key_i,
  input  logic [7:0]   s_data,
  input  logic         s_valid,
  input  logic         s_last,
  output logic         s_ready,
  output logic         init,
  output logic [256:0] key,
  output logic         din_valid,
  output logic [63:0]  din,
  output logic         sqz,
  input  logic [256:0] core_dout,
  output logic [256:0] digest,
  output logic         digest_valid,
  output logic         busy,
  output logic [2:0]   dbg_state
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_INIT   = 3'd1;
  localparam logic [2:0] ST_ABSORB = 3'd2;
  localparam logic [2:0] ST_PAD    = 3'd3;
  localparam logic [2:0] ST_FLUSH  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

`ifdef KOALA_FEEDER_PAD_EN
  localparam logic [63:0] PAD_BLOCK = 64'h0000_0000_0000_0001;
`else
  localparam logic [63:0] PAD_BLOCK = 64'h0000_0000_0000_0000;
`endif

  logic [2:0]   r_state;
  logic [256:0] r_key;
  logic         r_empty;
  logic [2:0]   r_idx;
  logic [63:0]  r_buf;
  logic [63:0]  r_blk;
  logic         r_blk_final;
  logic         r_din_valid;
  logic [63:0]  r_din;
  logic         r_sqz;
  logic [256:0] r_digest;

  logic         w_acc;
  logic         w_full;
  logic         w_emit;
  logic         w_final;
  logic         w_to_pad;
  logic [5:0]   w_bpos;
  logic [63:0]  w_cur;

  assign w_acc  = s_valid && (r_state == ST_ABSORB);
  assign w_full = (r_idx == 3'd7);
  assign w_emit = w_acc && (s_last || w_full);
  assign w_bpos = {r_idx, 3'b000};

`ifdef KOALA_FEEDER_PAD_EN
  logic [5:0] w_mpos;
  assign w_mpos   = {r_idx + 3'd1, 3'b000};
  assign w_final  = s_last && !w_full;
  assign w_to_pad = s_last && w_full;
`else
  assign w_final  = s_last;
  assign w_to_pad = 1'b0;
`endif

  // Buffer bytes above the current index are always zero, so only the marker needs inserting.
  always_comb begin
    w_cur = r_buf;
    w_cur[w_bpos +: 8] = s_data;
`ifdef KOALA_FEEDER_PAD_EN
    if (s_last && !w_full) w_cur[w_mpos +: 8] = 8'h01;
`endif
  end

  // Blocks are staged in r_blk for one cycle so din lands in the core's data cycle.
  always_ff @(posedge clk or posedge arstn) begin
    if (arstn) begin
      r_state     <= ST_IDLE;
      r_key       <= '0;
      r_empty     <= 1'b0;
      r_idx       <= '0;
      r_buf       <= '0;
      r_blk       <= '0;
      r_blk_final <= 1'b0;
      r_din_valid <= 1'b0;
      r_din       <= '0;
      r_sqz       <= 1'b0;
      r_digest    <= '0;
    end else begin
      r_din_valid <= 1'b0;
      r_sqz       <= r_din_valid && r_blk_final;
      if (r_din_valid) r_din <= r_blk;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_key   <= key_i;
            r_empty <= empty;
            r_idx   <= '0;
            r_buf   <= '0;
            r_state <= ST_INIT;
          end
        end
        ST_INIT: r_state <= r_empty ? ST_PAD : ST_ABSORB;
        ST_ABSORB: begin
          if (w_acc) begin
            r_idx <= r_idx + 3'd1;
            r_buf <= w_cur;
            if (w_emit) begin
              r_blk       <= w_cur;
              r_blk_final <= w_final;
              r_din_valid <= 1'b1;
              r_buf       <= '0;
              if (s_last) begin
                r_idx   <= '0;
                r_state <= w_to_pad ? ST_PAD : ST_FLUSH;
              end
            end
          end
        end
        ST_PAD: begin
          r_blk       <= PAD_BLOCK;
          r_blk_final <= 1'b1;
          r_din_valid <= 1'b1;
          r_state     <= ST_FLUSH;
        end
        ST_FLUSH: begin
          if (r_sqz) begin
            r_digest <= core_dout;
            r_state  <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s_ready      = (r_state == ST_ABSORB);
  assign init         = (r_state == ST_INIT);
  assign digest_valid = (r_state == ST_DONE);
  assign busy         = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign key          = r_key;
  assign din_valid    = r_din_valid;
  assign din          = r_din;
  assign sqz          = r_sqz;
  assign digest       = r_digest;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_koala_feeder.sv
// Directed bench for koala_feeder: block contents, emission skew, padding, digest capture, reset abort.
// Expected blocks follow KOALA_FEEDER_PAD_EN the same way the design does.
module tb_koala_feeder;

  logic         clk = 1'b0;
  logic         arstn = 1'b1;
  logic         start = 1'b0;
  logic         empty = 1'b0;
  logic [256:0] key_i = '0;
  logic [7:0]   s_data = '0;
  logic         s_valid = 1'b0;
  logic         s_last = 1'b0;
  logic         s_ready, init, din_valid, sqz, digest_valid, busy;
  logic [256:0] key, digest, core_dout;
  logic [63:0]  din;
  logic [2:0]   dbg_state;
  logic [63:0]  cyc = '0;

  int           total = 0;
  int           bad = 0;
  logic [64:0]  exp_q[$];
  logic         prev_dv = 1'b0;
  logic         dv_due = 1'b0;
  logic [256:0] exp_dig = '0;
  logic [256:0] cur_key = '0;
  int           dig_cnt = 0;
  int           dig0 = 0;
  logic [7:0]   msg[0:31];

  function automatic logic [256:0] gen(input logic [63:0] c);
    return {1'b1, c * 64'd3, c, ~c, c ^ 64'hA5A5_5A5A_C3C3_3C3C};
  endfunction

  // clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 64'd1;
  assign core_dout = gen(cyc);

  koala_feeder dut (
    .clk(clk), .arstn(arstn), .start(start), .empty(empty), .key_i(key_i),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .init(init), .key(key), .din_valid(din_valid), .din(din), .sqz(sqz),
    .core_dout(core_dout), .digest(digest), .digest_valid(digest_valid),
    .busy(busy), .dbg_state(dbg_state)
  );

  task automatic chk(input string tag, input logic [256:0] got, input logic [256:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // scoreboard: one block popped per data cycle, digest expected the cycle after a final block
  task automatic mon();
    logic [64:0] e;
    logic        q_empty;
    chk("digest_valid", digest_valid, dv_due);
    if (digest_valid && dv_due) begin
      chk("digest", digest, exp_dig);
      dig_cnt++;
    end
    dv_due = 1'b0;
    if (prev_dv) begin
      q_empty = (exp_q.size() == 0);
      chk("din_unexpected", q_empty, 1'b0);
      if (!q_empty) begin
        e = exp_q.pop_front();
        chk("din", din, e[63:0]);
        chk("sqz", sqz, e[64]);
        if (e[64]) begin
          exp_dig = gen(cyc);
          dv_due  = 1'b1;
        end
      end
    end else begin
      chk("sqz_idle", sqz, 1'b0);
    end
    prev_dv = din_valid;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    mon();
  endtask

  // driver tasks
  task automatic begin_msg(input logic emp, input logic [256:0] kv);
    dig0    = dig_cnt;
    cur_key = kv;
    start   = 1'b1;
    empty   = emp;
    key_i   = kv;
    step();
    start = 1'b0;
    empty = 1'b0;
    key_i = ~kv;
    chk("init_c1", init, 1'b1);
    chk("key_c1", key, kv);
    chk("busy_c1", busy, 1'b1);
    chk("no_dv_with_init", din_valid, 1'b0);
    if (!emp) begin
      step();
      chk("s_ready_c2", s_ready, 1'b1);
      chk("init_c2", init, 1'b0);
    end
  endtask

  task automatic send_bytes(input int n, input logic gappy, input int mid_start, input logic with_last);
    for (int i = 0; i < n; i++) begin
      int g;
      g = (gappy && (i % 3 == 2)) ? 2 : 0;
      for (int j = 0; j < g; j++) begin
        s_valid = 1'b0;
        start   = (i == mid_start) && (j == 0);
        step();
        chk("gap_init", init, 1'b0);
        chk("gap_s_ready", s_ready, 1'b1);
      end
      start   = 1'b0;
      s_valid = 1'b1;
      s_data  = msg[i];
      s_last  = with_last && (i == n - 1);
      chk("s_ready_byte", s_ready, 1'b1);
      step();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (dig_cnt == dig0 && k < 30) begin
      step();
      k++;
    end
    chk("digest_count", dig_cnt - dig0, 1);
    chk("blocks_left", exp_q.size(), 0);
    step();
    chk("digest_hold", digest, exp_dig);
    chk("key_hold", key, cur_key);
    chk("busy_idle", busy, 1'b0);
    chk("s_ready_idle", s_ready, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #3 arstn = 1'b0;

    // reset state then 20 quiet cycles
    #1;
    chk("rst_digest", digest, '0);
    chk("rst_din", din, '0);
    chk("rst_key", key, '0);
    chk("rst_state", dbg_state, 3'd0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_s_ready", s_ready, 1'b0);
      chk("idle_init", init, 1'b0);
      chk("idle_din_valid", din_valid, 1'b0);
      chk("idle_busy", busy, 1'b0);
    end

    // 3-byte message AA BB CC
    msg[0] = 8'hAA; msg[1] = 8'hBB; msg[2] = 8'hCC;
`ifdef KOALA_FEEDER_PAD_EN
    exp_q.push_back({1'b1, 64'h0000_0000_01CC_BBAA});
`else
    exp_q.push_back({1'b1, 64'h0000_0000_00CC_BBAA});
`endif
    begin_msg(1'b0, {1'b1, {8{32'hDEAD_BEEF}}});
    send_bytes(3, 1'b0, -1, 1'b1);
    chk("m3_dv_c1", din_valid, 1'b1);
    chk("m3_s_ready_c1", s_ready, 1'b0);
    step();
    chk("m3_sqz_c2", sqz, 1'b1);
    step();
    chk("m3_dvalid_c3", digest_valid, 1'b1);
    wait_done();

    // 8-byte message 01..08
    for (int i = 0; i < 8; i++) msg[i] = 8'(i + 1);
`ifdef KOALA_FEEDER_PAD_EN
    exp_q.push_back({1'b0, 64'h0807_0605_0403_0201});
    exp_q.push_back({1'b1, 64'h0000_0000_0000_0001});
`else
    exp_q.push_back({1'b1, 64'h0807_0605_0403_0201});
`endif
    begin_msg(1'b0, {1'b0, {4{64'h0123_4567_89AB_CDEF}}});
    send_bytes(8, 1'b0, -1, 1'b1);
    chk("m8_dv_c1", din_valid, 1'b1);
    chk("m8_s_ready_c1", s_ready, 1'b0);
    step();
`ifdef KOALA_FEEDER_PAD_EN
    chk("m8_dv_c2", din_valid, 1'b1);
    chk("m8_sqz_c2", sqz, 1'b0);
    step();
    chk("m8_sqz_c3", sqz, 1'b1);
`else
    chk("m8_sqz_c2", sqz, 1'b1);
    chk("m8_dv_c2", din_valid, 1'b0);
`endif
    wait_done();

    // empty message
`ifdef KOALA_FEEDER_PAD_EN
    exp_q.push_back({1'b1, 64'h0000_0000_0000_0001});
`else
    exp_q.push_back({1'b1, 64'h0000_0000_0000_0000});
`endif
    begin_msg(1'b1, {1'b1, {8{32'h1357_9BDF}}});
    step();
    chk("empty_s_ready_c2", s_ready, 1'b0);
    step();
    chk("empty_dv_c3", din_valid, 1'b1);
    wait_done();

    // 17 bytes with gaps and an ignored mid-message start
    for (int i = 0; i < 17; i++) msg[i] = 8'h10 + 8'(i);
    exp_q.push_back({1'b0, 64'h1716_1514_1312_1110});
    exp_q.push_back({1'b0, 64'h1F1E_1D1C_1B1A_1918});
`ifdef KOALA_FEEDER_PAD_EN
    exp_q.push_back({1'b1, 64'h0000_0000_0000_0120});
`else
    exp_q.push_back({1'b1, 64'h0000_0000_0000_0020});
`endif
    begin_msg(1'b0, {1'b0, {8{32'h0F0F_F0F0}}});
    send_bytes(17, 1'b1, 8, 1'b1);
    chk("m17_dv_c1", din_valid, 1'b1);
    wait_done();

    // reset mid-ABSORB after one block went out
    for (int i = 0; i < 10; i++) msg[i] = 8'h30 + 8'(i);
    exp_q.push_back({1'b0, 64'h3736_3534_3332_3130});
    begin_msg(1'b0, {1'b1, {8{32'hCAFE_F00D}}});
    send_bytes(10, 1'b0, -1, 1'b0);
    chk("pre_rst_din", din, 64'h3736_3534_3332_3130);
    #3 arstn = 1'b1;
    #1;
    chk("arst_din", din, '0);
    chk("arst_key", key, '0);
    chk("arst_digest", digest, '0);
    chk("arst_s_ready", s_ready, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_din_valid", din_valid, 1'b0);
    chk("arst_state", dbg_state, 3'd0);
    #1 arstn = 1'b0;
    exp_q.delete();
    prev_dv = 1'b0;
    dv_due  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("post_rst_idle", dbg_state, 3'd0);
    end

    // clean message after reset
    msg[0] = 8'h11; msg[1] = 8'h22;
`ifdef KOALA_FEEDER_PAD_EN
    exp_q.push_back({1'b1, 64'h0000_0000_0001_2211});
`else
    exp_q.push_back({1'b1, 64'h0000_0000_0000_2211});
`endif
    begin_msg(1'b0, {1'b0, {8{32'h2468_ACE0}}});
    send_bytes(2, 1'b0, -1, 1'b1);
    chk("m2_dv_c1", din_valid, 1'b1);
    wait_done();

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
